// File: rtl/dds_pkg.sv
// dds_pkg: shared encodings for the DDS ROM sequencer.
// Holds wave select codes, FSM states and the config bundle width helper.
package dds_pkg;

    localparam int WAVE_W = 2;

    localparam logic [WAVE_W-1:0] WAVE_SINE   = 2'd0;
    localparam logic [WAVE_W-1:0] WAVE_SQUARE = 2'd1;
    localparam logic [WAVE_W-1:0] WAVE_TRI    = 2'd2;
    localparam logic [WAVE_W-1:0] WAVE_SAW    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Packed config bundle: {ftw, phase, wave_sel, amp}
    function automatic int cfg_width(int acc_w, int addr_w, int data_w);
        return acc_w + addr_w + WAVE_W + data_w;
    endfunction

endpackage

// File: rtl/dds_amp_scale.sv
// dds_amp_scale: aligns issue tags with ROM read data and scales the sample.
// Ports: issue_valid/issue_sel/issue_amp tag each ROM address; rd_data is
// the selected ROM output; sel is the tag aligned to rd_data (external mux);
// dac_data/dac_valid are the registered scaled sample and its strobe.
module dds_amp_scale
    import dds_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] MIDSCALE = DATA_WIDTH'(1 << (DATA_WIDTH - 1))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [WAVE_W-1:0]     issue_sel,
    input  logic [DATA_WIDTH-1:0] issue_amp,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [WAVE_W-1:0]     sel,
    output logic [DATA_WIDTH-1:0] dac_data,
    output logic                  dac_valid
);

    localparam int PW = 2 * DATA_WIDTH + 1;

    logic                  v_pipe   [ROM_LATENCY];
    logic [WAVE_W-1:0]     sel_pipe [ROM_LATENCY];
    logic [DATA_WIDTH-1:0] amp_pipe [ROM_LATENCY];
    logic [PW-1:0]         prod;

    // amp+1 makes all-ones an exact unity gain after the shift
    assign prod = PW'(rd_data) * (PW'(amp_pipe[ROM_LATENCY-1]) + PW'(1));
    assign sel  = sel_pipe[ROM_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                v_pipe[i]   <= 1'b0;
                sel_pipe[i] <= WAVE_SINE;
                amp_pipe[i] <= '0;
            end
            dac_data  <= MIDSCALE;
            dac_valid <= 1'b0;
        end else begin
            v_pipe[0]   <= issue_valid;
            sel_pipe[0] <= issue_sel;
            amp_pipe[0] <= issue_amp;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                v_pipe[i]   <= v_pipe[i-1];
                sel_pipe[i] <= sel_pipe[i-1];
                amp_pipe[i] <= amp_pipe[i-1];
            end
            dac_valid <= v_pipe[ROM_LATENCY-1];
            if (v_pipe[ROM_LATENCY-1]) begin
                dac_data <= DATA_WIDTH'(prod >> DATA_WIDTH);
            end
        end
    end

endmodule

// File: rtl/dds_rom_ctrl.sv
// dds_rom_ctrl: phase-accumulator sequencer for the waveform ROMs feeding the DAC.
// Ports: run level enables generation; cfg_* is a valid/ready config channel;
// rom_addr/rom_sel/rom_rd_data talk to the ROMs; dac_data/dac_valid carry
// scaled samples; wrap pulses on accumulator carry; busy is high out of IDLE.
module dds_rom_ctrl
    import dds_pkg::*;
#(
    parameter int ACC_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] MIDSCALE = DATA_WIDTH'(1 << (DATA_WIDTH - 1))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ACC_WIDTH-1:0]  cfg_ftw,
    input  logic [ADDR_WIDTH-1:0] cfg_phase,
    input  logic [1:0]            cfg_wave_sel,
    input  logic [DATA_WIDTH-1:0] cfg_amp,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [1:0]            rom_sel,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic [DATA_WIDTH-1:0] dac_data,
    output logic                  dac_valid,
    output logic                  wrap,
    output logic                  busy
);

    localparam int CW = cfg_width(ACC_WIDTH, ADDR_WIDTH, DATA_WIDTH);

    state_t state;

    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  ftw_a;
    logic [ADDR_WIDTH-1:0] phase_a;
    logic [1:0]            wave_a;
    logic [DATA_WIDTH-1:0] amp_a;

    logic [CW-1:0]         shadow;
    logic                  pending;
    logic [1:0]            drain_cnt;

    logic                  iss_valid;
    logic [1:0]            iss_sel;
    logic [DATA_WIDTH-1:0] iss_amp;

    logic [CW-1:0]         cfg_in;
    logic [ACC_WIDTH-1:0]  ftw_s;
    logic [ADDR_WIDTH-1:0] phase_s;
    logic [1:0]            wave_s;
    logic [DATA_WIDTH-1:0] amp_s;

    logic [ACC_WIDTH-1:0]  acc_sum;
    logic                  carry;
    logic                  xfer;
    logic                  apply;
    logic [ADDR_WIDTH-1:0] run_phase;
    logic [1:0]            run_wave;
    logic [DATA_WIDTH-1:0] run_amp;

    assign cfg_in = {cfg_ftw, cfg_phase, cfg_wave_sel, cfg_amp};
    assign {ftw_s, phase_s, wave_s, amp_s} = shadow;

    assign cfg_ready = (state == S_RUN) ? !pending : 1'b1;
    assign busy      = (state != S_IDLE);
    assign xfer      = cfg_valid && cfg_ready;

    assign {carry, acc_sum} = {1'b0, acc} + {1'b0, ftw_a};

    // On a wrap with a pending config, the post-wrap sample already uses
    // the new phase/wave/amp; the new ftw drives the following steps.
    assign apply     = carry && pending;
    assign run_phase = apply ? phase_s : phase_a;
    assign run_wave  = apply ? wave_s : wave_a;
    assign run_amp   = apply ? amp_s : amp_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            ftw_a     <= '0;
            phase_a   <= '0;
            wave_a    <= WAVE_SINE;
            amp_a     <= '0;
            shadow    <= '0;
            pending   <= 1'b0;
            drain_cnt <= '0;
            rom_addr  <= '0;
            wrap      <= 1'b0;
            iss_valid <= 1'b0;
            iss_sel   <= WAVE_SINE;
            iss_amp   <= '0;
        end else begin
            wrap      <= 1'b0;
            iss_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (xfer) begin
                        {ftw_a, phase_a, wave_a, amp_a} <= cfg_in;
                    end
                    if (run) begin
                        // acc is zero here, so the first address is the phase
                        state     <= S_RUN;
                        iss_valid <= 1'b1;
                        rom_addr  <= xfer ? cfg_phase : phase_a;
                        iss_sel   <= xfer ? cfg_wave_sel : wave_a;
                        iss_amp   <= xfer ? cfg_amp : amp_a;
                    end
                end
                S_RUN: begin
                    if (!run) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        acc       <= acc_sum;
                        wrap      <= carry;
                        iss_valid <= 1'b1;
                        rom_addr  <= acc_sum[ACC_WIDTH-1 -: ADDR_WIDTH] + run_phase;
                        iss_sel   <= run_wave;
                        iss_amp   <= run_amp;
                        if (apply) begin
                            {ftw_a, phase_a, wave_a, amp_a} <= shadow;
                            pending <= 1'b0;
                        end
                    end
                    // xfer implies !pending, so it never collides with apply
                    if (xfer) begin
                        shadow  <= cfg_in;
                        pending <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 2'(ROM_LATENCY)) begin
                        state <= S_IDLE;
                        acc   <= '0;
                        if (pending) begin
                            {ftw_a, phase_a, wave_a, amp_a} <= shadow;
                            pending <= 1'b0;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                    // a direct load here is newer than any held shadow
                    if (xfer) begin
                        {ftw_a, phase_a, wave_a, amp_a} <= cfg_in;
                        pending <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    dds_amp_scale #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ROM_LATENCY (ROM_LATENCY),
        .MIDSCALE    (MIDSCALE)
    ) u_scale (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (iss_valid),
        .issue_sel   (iss_sel),
        .issue_amp   (iss_amp),
        .rd_data     (rom_rd_data),
        .sel         (rom_sel),
        .dac_data    (dac_data),
        .dac_valid   (dac_valid)
    );

endmodule

// File: tb/tb_dds_rom_ctrl.sv
// tb_dds_rom_ctrl: directed and random stimulus for dds_rom_ctrl against
// a transaction-level reference model with a sample queue.
module tb_dds_rom_ctrl;
    import dds_pkg::*;

    localparam int L = 1;
    localparam longint MOD = 64'd1 << 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_ftw;
    logic [9:0]  cfg_phase;
    logic [1:0]  cfg_wave_sel;
    logic [7:0]  cfg_amp;
    logic [9:0]  rom_addr;
    logic [1:0]  rom_sel;
    logic [7:0]  rom_rd_data;
    logic [7:0]  dac_data;
    logic        dac_valid;
    logic        wrap;
    logic        busy;

    always #5 clk = ~clk;

    dds_rom_ctrl #(
        .ACC_WIDTH   (32),
        .ADDR_WIDTH  (10),
        .DATA_WIDTH  (8),
        .ROM_LATENCY (L),
        .MIDSCALE    (8'h80)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ftw      (cfg_ftw),
        .cfg_phase    (cfg_phase),
        .cfg_wave_sel (cfg_wave_sel),
        .cfg_amp      (cfg_amp),
        .rom_addr     (rom_addr),
        .rom_sel      (rom_sel),
        .rom_rd_data  (rom_rd_data),
        .dac_data     (dac_data),
        .dac_valid    (dac_valid),
        .wrap         (wrap),
        .busy         (busy)
    );

    // ROM bank: synchronous read, external mux on aligned rom_sel
    logic [7:0] mem [4][1024];
    logic [7:0] rq  [4];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) rq[k] <= mem[k][rom_addr];
    end
    assign rom_rd_data = rq[rom_sel];

    // reference model
    typedef struct {
        longint ftw;
        int     phase;
        int     wave;
        int     amp;
    } cfg_t;

    typedef struct {
        int due;
        int data;
    } smp_t;

    smp_t   pipe[$];
    cfg_t   act, shd, cin;
    bit     pend;
    int     mode;
    int     drain_left;
    longint m_acc;
    int     cyc;
    int     e_addr, e_dac, e_valid, e_wrap;
    int     prev_wave, cur_wave;
    bit     prev_iss, cur_iss;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                      tag, got, exp, $time);
    endtask

    function automatic int scale(int d, int a);
        return (d * (a + 1)) / 256;
    endfunction

    function automatic int ref_addr(longint acc, int ph);
        return int'(((acc >> 22) + longint'(ph)) % 1024);
    endfunction

    task automatic issue(int addr, cfg_t c);
        smp_t s;
        s.due   = cyc + L + 1;
        s.data  = scale(int'(mem[c.wave][addr]), c.amp);
        e_addr  = addr;
        cur_iss = 1;
        cur_wave = c.wave;
        pipe.push_back(s);
    endtask

    task automatic model_step();
        bit     xfer;
        longint sum;
        cyc++;
        prev_iss  = cur_iss;
        prev_wave = cur_wave;
        cur_iss   = 0;
        e_wrap    = 0;
        e_valid   = 0;
        if (rst) begin
            mode = 0; m_acc = 0; pend = 0;
            act = '{0, 0, 0, 0}; shd = act;
            pipe.delete();
            e_addr = 0; e_dac = 128;
            prev_iss = 0; cur_wave = 0; prev_wave = 0;
            return;
        end
        cin  = '{longint'(cfg_ftw), int'(cfg_phase), int'(cfg_wave_sel), int'(cfg_amp)};
        xfer = cfg_valid && ((mode == 1) ? !pend : 1'b1);
        if (pipe.size() > 0 && pipe[0].due == cyc) begin
            e_dac   = pipe[0].data;
            e_valid = 1;
            void'(pipe.pop_front());
        end
        case (mode)
            0: begin
                if (xfer) act = cin;
                if (run) begin
                    mode = 1;
                    issue(ref_addr(m_acc, act.phase), act);
                end
            end
            1: begin
                if (!run) begin
                    mode = 2;
                    drain_left = L + 1;
                end else begin
                    sum   = m_acc + act.ftw;
                    m_acc = sum % MOD;
                    if (sum >= MOD) begin
                        e_wrap = 1;
                        if (pend) begin
                            // new config owns the post-wrap sample
                            issue(ref_addr(m_acc, shd.phase), shd);
                            act  = shd;
                            pend = 0;
                        end else begin
                            issue(ref_addr(m_acc, act.phase), act);
                        end
                    end else begin
                        issue(ref_addr(m_acc, act.phase), act);
                    end
                end
                if (xfer) begin
                    shd  = cin;
                    pend = 1;
                end
            end
            default: begin
                drain_left--;
                if (drain_left == 0) begin
                    mode  = 0;
                    m_acc = 0;
                    if (pend) begin
                        act  = shd;
                        pend = 0;
                    end
                end
                if (xfer) begin
                    act  = cin;
                    pend = 0;
                end
            end
        endcase
    endtask

    task automatic check_all();
        check("addr", 32'(rom_addr), 32'(e_addr));
        check("valid", 32'(dac_valid), 32'(e_valid));
        check("dac", 32'(dac_data), 32'(e_dac));
        check("wrap", 32'(wrap), 32'(e_wrap));
        check("busy", 32'(busy), 32'(mode != 0));
        check("ready", 32'(cfg_ready), 32'((mode == 1) ? !pend : 1'b1));
        if (prev_iss) check("sel", 32'(rom_sel), 32'(prev_wave));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_cfg(input logic v, input logic [31:0] f,
                           input logic [9:0] p, input logic [1:0] w,
                           input logic [7:0] a);
        cfg_valid    = v;
        cfg_ftw      = f;
        cfg_phase    = p;
        cfg_wave_sel = w;
        cfg_amp      = a;
    endtask

    initial begin
        int guard;
        int nwrap;
        logic [7:0] amps [3];
        logic [7:0] exps [3];
        amps = '{8'h7F, 8'h00, 8'hFF};
        exps = '{8'h7F, 8'h00, 8'hFF};

        for (int a = 0; a < 1024; a++) begin
            mem[0][a] = 8'($urandom);
            mem[1][a] = (a < 512) ? 8'hFF : 8'h00;
            mem[2][a] = (a < 512) ? 8'(a >> 1) : 8'((1023 - a) >> 1);
            mem[3][a] = 8'(a >> 2);
        end

        rst = 1'b1;
        run = 1'b0;
        set_cfg(1'b0, '0, '0, WAVE_SINE, '0);
        @(negedge clk);
        repeat (3) tick();
        check("rst_dac", 32'(dac_data), 32'h80);
        check("rst_valid", 32'(dac_valid), 0);
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(cfg_ready), 1);
        check("rst_sel", 32'(rom_sel), 0);
        rst = 1'b0;

        // sawtooth sweep, config taken on the IDLE->RUN edge
        set_cfg(1'b1, 32'h0040_0000, 10'h000, WAVE_SAW, 8'hFF);
        run = 1'b1;
        tick();
        set_cfg(1'b0, '0, '0, WAVE_SINE, '0);
        check("saw_a0", 32'(rom_addr), 0);
        tick();
        check("saw_a1", 32'(rom_addr), 1);
        check("saw_nv", 32'(dac_valid), 0);
        tick();
        check("saw_v", 32'(dac_valid), 1);
        check("saw_d0", 32'(dac_data), 32'(mem[3][0]));
        nwrap = 0;
        repeat (1100) begin
            tick();
            if (wrap === 1'b1) nwrap++;
        end
        check("saw_wraps", 32'(nwrap), 1);

        // mid-run reconfiguration at address 0x200
        guard = 0;
        while (rom_addr !== 10'h200 && guard < 2048) begin
            tick();
            guard++;
        end
        check("reach_200", 32'(rom_addr), 32'h200);
        set_cfg(1'b1, 32'h0080_0000, 10'h000, WAVE_SINE, 8'hFF);
        tick();
        set_cfg(1'b0, '0, '0, WAVE_SINE, '0);
        check("mid_ready", 32'(cfg_ready), 0);
        guard = 0;
        while (wrap !== 1'b1 && guard < 2048) begin
            tick();
            guard++;
        end
        check("mid_wrap", 32'(wrap), 1);
        check("post_wrap_addr", 32'(rom_addr), 0);
        tick();
        check("post_wrap_sel", 32'(rom_sel), 32'(WAVE_SINE));
        check("new_ftw_addr", 32'(rom_addr), 2);
        check("ready_back", 32'(cfg_ready), 1);
        tick();
        check("first_sine", 32'(dac_data), 32'(mem[0][0]));

        // stop: drain then idle
        run = 1'b0;
        tick();
        tick();
        check("drain_trail", 32'(dac_valid), 1);
        check("drain_busy", 32'(busy), 1);
        tick();
        check("drain_quiet", 32'(dac_valid), 0);
        check("idle_busy", 32'(busy), 0);

        // restart with half-rate ftw and phase offset
        set_cfg(1'b1, 32'h8000_0000, 10'h100, WAVE_SAW, 8'hFF);
        run = 1'b1;
        tick();
        set_cfg(1'b0, '0, '0, WAVE_SINE, '0);
        check("rs_a0", 32'(rom_addr), 32'h100);
        tick();
        check("rs_a1", 32'(rom_addr), 32'h300);
        check("rs_nowrap", 32'(wrap), 0);
        tick();
        check("rs_a2", 32'(rom_addr), 32'h100);
        check("rs_wrap", 32'(wrap), 1);
        repeat (17) tick();

        // amplitude scaling on full-scale square data
        for (int i = 0; i < 3; i++) begin
            run = 1'b0;
            repeat (4) tick();
            set_cfg(1'b1, 32'h0, 10'h000, WAVE_SQUARE, amps[i]);
            run = 1'b1;
            tick();
            set_cfg(1'b0, '0, '0, WAVE_SINE, '0);
            repeat (3) tick();
            check($sformatf("amp_%0h", amps[i]), 32'(dac_data), 32'(exps[i]));
        end

        // ftw=0 holds a pending config until IDLE
        set_cfg(1'b1, 32'h0040_0000, 10'd5, WAVE_TRI, 8'h80);
        tick();
        set_cfg(1'b0, '0, '0, WAVE_SINE, '0);
        check("hold_ready", 32'(cfg_ready), 0);
        repeat (10) tick();
        check("hold_addr", 32'(rom_addr), 0);
        check("hold_ready2", 32'(cfg_ready), 0);
        run = 1'b0;
        repeat (4) tick();
        check("idle_ready", 32'(cfg_ready), 1);
        run = 1'b1;
        tick();
        check("apply_addr", 32'(rom_addr), 5);
        tick();
        check("apply_sel", 32'(rom_sel), 32'(WAVE_TRI));

        // reset mid-run with a pending config
        set_cfg(1'b1, 32'h0010_0000, 10'd7, WAVE_SAW, 8'hFF);
        tick();
        set_cfg(1'b0, '0, '0, WAVE_SINE, '0);
        check("pend_set", 32'(cfg_ready), 0);
        tick();
        rst = 1'b1;
        run = 1'b0;
        tick();
        check("mrst_dac", 32'(dac_data), 32'h80);
        check("mrst_valid", 32'(dac_valid), 0);
        check("mrst_addr", 32'(rom_addr), 0);
        check("mrst_ready", 32'(cfg_ready), 1);
        rst = 1'b0;
        run = 1'b1;
        tick();
        check("mrst_run_addr", 32'(rom_addr), 0);
        check("mrst_pend_clr", 32'(cfg_ready), 1);

        // randomized traffic
        repeat (4000) begin
            if ($urandom_range(0, 49) == 0) run = ~run;
            set_cfg($urandom_range(0, 19) == 0,
                    $urandom >> $urandom_range(0, 12),
                    10'($urandom), 2'($urandom), 8'($urandom));
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;
        run = 1'b0;
        cfg_valid = 1'b0;
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dds_rom_ctrl.md
Name: dds_rom_ctrl

Overview:
- Phase-accumulator sequencer for the single-port waveform ROMs (sine/square/triangle/sawtooth, 1024x8, unregistered output, 1-cycle read latency) feeding the AD9708 DAC on PGL50H.
- Generates ROM addresses from a frequency tuning word and phase offset, and selects which ROM drives the data path.
- Applies amplitude scaling and presents DAC samples with a valid strobe.
- Accepts runtime reconfiguration via valid/ready; mid-run changes take effect only at a phase wrap, so frequency and waveform switch glitch-free.

Parameters:
- ACC_WIDTH, 32: phase accumulator width.
- ADDR_WIDTH, 10: ROM address width; must be less than ACC_WIDTH.
- DATA_WIDTH, 8: ROM and DAC sample width.
- ROM_LATENCY, 1: cycles from rom_addr to valid rom_rd_data (1 or 2).
- MIDSCALE, 2**(DATA_WIDTH-1): DAC idle/reset code.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- run  in  1  level; 1 = generate, 0 = stop.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted this cycle.
- cfg_ftw  in  ACC_WIDTH  frequency tuning word.
- cfg_phase  in  ADDR_WIDTH  phase offset added to the address.
- cfg_wave_sel  in  2  waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- cfg_amp  in  DATA_WIDTH  amplitude; all-ones = unity.
- rom_addr  out  ADDR_WIDTH  address to all ROMs.
- rom_sel  out  2  external mux select for ROM read data, aligned to rom_rd_data.
- rom_rd_data  in  DATA_WIDTH  selected ROM output.
- dac_data  out  DATA_WIDTH  scaled sample.
- dac_valid  out  1  dac_data updated this cycle.
- wrap  out  1  one-cycle pulse on accumulator carry-out.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: acc=0, active and shadow config = 0, pending=0, rom_addr=0, rom_sel=0, dac_data=MIDSCALE, dac_valid=0, wrap=0, busy=0, state=IDLE.
- Reset mid-operation returns every output to its reset value on the next edge. No pipeline data survives reset.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when run=1.
  - RUN -> DRAIN when run=0.
  - DRAIN -> IDLE after ROM_LATENCY+1 cycles.
  - A run re-assert during DRAIN is ignored until IDLE is reached.
- Configuration handshake: a transfer occurs when cfg_valid && cfg_ready.
  - In IDLE or DRAIN, cfg_ready=1 and the transfer loads the active registers directly.
  - In RUN, cfg_ready = !pending. The transfer loads the shadow registers and sets pending.
  - A transfer in the same cycle IDLE->RUN is taken is used for the first RUN address.
- Accumulator: in RUN, each cycle {carry, acc} <= acc + ftw_active.
  - rom_addr <= acc_next[ACC_WIDTH-1 -: ADDR_WIDTH] + phase_active, wrapping mod 2**ADDR_WIDTH.
  - Entering IDLE clears acc, so a restart is phase-coherent and begins at address phase_active.
- Wrap: carry=1 pulses wrap. If pending, shadow is copied to active on that edge (pending cleared), so the next address uses the new ftw/phase/wave.
  - Apply is atomic: all three fields plus amp switch together. amp switches when the first new-config sample reaches the multiplier, by carrying it down the pipeline with rom_sel.
- ftw=0 in RUN: constant address, no wrap, pending is held. The shadow is applied on entry to IDLE.
- run falling while pending: shadow is applied on entry to IDLE.
- Data pipeline:
  - rom_sel and an issue-valid bit are delayed ROM_LATENCY cycles to align with rom_rd_data.
  - Scale stage: dac_data <= (rom_rd_data * (amp+1)) >> DATA_WIDTH. The product is DATA_WIDTH*2+1 bits, with no rounding.
  - dac_valid = aligned issue-valid.
- Latency: address issued at edge N gives dac_data/dac_valid at edge N+ROM_LATENCY+1.
- In DRAIN, no new addresses are issued and in-flight samples are still output. Afterwards dac_data holds its last value and dac_valid=0.

Decomposition:
- Package dds_pkg holds:
  - the wave_sel encoding constants (WAVE_SINE=0, WAVE_SQUARE=1, WAVE_TRI=2, WAVE_SAW=3);
  - state encodings;
  - a cfg struct/bundle width constant.
- One sub-module, dds_amp_scale: the registered multiply-shift stage with aligned valid and sel. This keeps the arithmetic unit-testable.

Test Plan:
- ftw=0x0040_0000, phase=0, saw ROM model, amp=0xFF, run=1 -> rom_addr 0,1,2,...; first dac_valid 2 cycles after the first address; dac_data equals ROM content; wrap pulses every 1024 cycles.
- ftw=0x8000_0000, phase=0x100 -> rom_addr alternates 0x100, 0x300; wrap every 2nd cycle.
- Mid-run cfg (ftw=0x0080_0000, wave=sine) at address 0x200 -> cfg_ready drops; old config runs until wrap; the first post-wrap address is 0; rom_sel changes exactly on that sample; no stale mix.
- amp=0x7F, ROM data 0xFF -> dac_data=0x7F; amp=0x00 -> 0x00; amp=0xFF -> 0xFF.
- run=0 during RUN -> DRAIN for 2 cycles; exactly 1 trailing dac_valid; busy falls; restart begins at address phase.
- rst asserted mid-RUN with pending=1 -> next edge: dac_data=0x80, dac_valid=0, rom_addr=0, cfg_ready=1, pending cleared.
